// File: rtl/barrel_sched.sv
// barrel_sched: barrel-style thread scheduler issuing at most one fetch per cycle.
// Define BARREL_SKIP_EN to skip ineligible threads instead of issuing bubbles.
module barrel_sched #(
    parameter int              NTHREADS = 4,
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    localparam int             TID_W    = (NTHREADS > 1) ? $clog2(NTHREADS) : 1
) (
    input  logic             clk,
    input  logic             resetn,
    output logic             issue_valid,
    output logic [TID_W-1:0] issue_tid,
    output logic [PC_W-1:0]  issue_pc,
    input  logic             wb_valid,
    input  logic [TID_W-1:0] wb_tid,
    input  logic [PC_W-1:0]  wb_next_pc,
    input  logic             wb_halt,
    input  logic             start_valid,
    input  logic [TID_W-1:0] start_tid,
    input  logic [PC_W-1:0]  start_pc,
    output logic             halt
);

    logic [PC_W-1:0]     pc_q [NTHREADS];
    logic [PC_W-1:0]     pc_d [NTHREADS];
    logic [NTHREADS-1:0] running_q, running_d;
    logic [NTHREADS-1:0] inflight_q, inflight_d;
    logic [NTHREADS-1:0] eligible;
    logic [TID_W-1:0]    ptr_q, ptr_d;
    logic [TID_W-1:0]    sel;
    logic                found;
    logic                issue_valid_q, issue_valid_d;
    logic [TID_W-1:0]    issue_tid_q, issue_tid_d;
    logic [PC_W-1:0]     issue_pc_q, issue_pc_d;
    logic                halt_q, halt_d;
`ifdef BARREL_SKIP_EN
    logic [TID_W-1:0]    cand;
`endif

    assign eligible = running_q & ~inflight_q;

    // Thread selection works purely on registered state.
    always_comb begin
        found = 1'b0;
        sel   = ptr_q;
        ptr_d = ptr_q;
`ifdef BARREL_SKIP_EN
        cand = ptr_q;
        for (int k = 0; k < NTHREADS; k++) begin
            cand = ptr_q + TID_W'(k);
            if (!found && eligible[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
        if (found) begin
            ptr_d = sel + TID_W'(1);
        end
`else
        found = eligible[ptr_q];
        ptr_d = ptr_q + TID_W'(1);
`endif
    end

    // Issue only touches threads with inflight=0 and wb only threads with
    // inflight=1, so the three updates never target the same thread.
    always_comb begin
        pc_d          = pc_q;
        running_d     = running_q;
        inflight_d    = inflight_q;
        issue_valid_d = found;
        issue_tid_d   = issue_tid_q;
        issue_pc_d    = issue_pc_q;
        if (found) begin
            inflight_d[sel] = 1'b1;
            issue_tid_d     = sel;
            issue_pc_d      = pc_q[sel];
        end
        if (wb_valid && inflight_q[wb_tid]) begin
            inflight_d[wb_tid] = 1'b0;
            pc_d[wb_tid]       = wb_next_pc;
            if (wb_halt) begin
                running_d[wb_tid] = 1'b0;
            end
        end
        if (start_valid && !running_q[start_tid] && !inflight_q[start_tid]) begin
            running_d[start_tid] = 1'b1;
            pc_d[start_tid]      = start_pc;
        end
        halt_d = ~|running_d && ~|inflight_d;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < NTHREADS; i++) begin
                pc_q[i] <= RESET_PC;
            end
            running_q     <= NTHREADS'(1);
            inflight_q    <= '0;
            ptr_q         <= '0;
            issue_valid_q <= 1'b0;
            issue_tid_q   <= '0;
            issue_pc_q    <= RESET_PC;
            halt_q        <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            running_q     <= running_d;
            inflight_q    <= inflight_d;
            ptr_q         <= ptr_d;
            issue_valid_q <= issue_valid_d;
            issue_tid_q   <= issue_tid_d;
            issue_pc_q    <= issue_pc_d;
            halt_q        <= halt_d;
        end
    end

    assign issue_valid = issue_valid_q;
    assign issue_tid   = issue_tid_q;
    assign issue_pc    = issue_pc_q;
    assign halt        = halt_q;

endmodule
